// File: rtl/pulse_gen.sv
// Step/direction pulse generator: one move command produces PulseNum step pulses on the selected motor.
// Optional DIR_SETUP_EN macro inserts a direction setup hold before the first step edge.
module pulse_gen #(
    parameter int unsigned HALF_PERIOD = 500,
    parameter int unsigned DIR_SETUP   = 20
) (
    input  logic       sysclk,
    input  logic       INIT_n,
    input  logic       CmdValid,
    input  logic [5:0] MotorIn,
    input  logic [9:0] PulseNum,
    input  logic [5:0] DRIn,
    output logic       Busy,
    output logic [5:0] Step,
    output logic [5:0] DR,
    output logic       Done,
    output logic       Err
);

    localparam int unsigned PH_MAX = (HALF_PERIOD > DIR_SETUP) ? HALF_PERIOD : DIR_SETUP;
    localparam int unsigned PW     = $clog2(PH_MAX + 1);
    localparam logic [PW-1:0] HP_LOAD = PW'(HALF_PERIOD - 1);
`ifdef DIR_SETUP_EN
    localparam logic [PW-1:0] SU_LOAD = PW'(DIR_SETUP - 1);
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HIGH  = 2'd1,
        LOW   = 2'd2
`ifdef DIR_SETUP_EN
        , SETUP = 2'd3
`endif
    } state_t;

    state_t        state, state_nx;
    logic [PW-1:0] phase, phase_nx;
    logic [9:0]    count, count_nx;
    logic [5:0]    sel, sel_nx;
    logic [5:0]    step_nx, dr_nx;
    logic          busy_nx, done_nx, err_nx;
    logic          cmd_onehot;

    assign cmd_onehot = (MotorIn != '0) && ((MotorIn & (MotorIn - 6'd1)) == '0);

    always_ff @(posedge sysclk or negedge INIT_n) begin
        if (!INIT_n) begin
            state <= IDLE;
            phase <= '0;
            count <= '0;
            sel   <= '0;
            Step  <= '0;
            DR    <= '0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
            Err   <= 1'b0;
        end else begin
            state <= state_nx;
            phase <= phase_nx;
            count <= count_nx;
            sel   <= sel_nx;
            Step  <= step_nx;
            DR    <= dr_nx;
            Busy  <= busy_nx;
            Done  <= done_nx;
            Err   <= err_nx;
        end
    end

    // Step is computed one cycle ahead so the registered output lines up with the state.
    always_comb begin
        state_nx = state;
        phase_nx = phase;
        count_nx = count;
        sel_nx   = sel;
        step_nx  = Step;
        dr_nx    = DR;
        busy_nx  = Busy;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (CmdValid) begin
                    if (!cmd_onehot) begin
                        err_nx = 1'b1;
                    end else if (PulseNum == '0) begin
                        done_nx = 1'b1;
                    end else begin
                        sel_nx   = MotorIn;
                        count_nx = PulseNum;
                        dr_nx    = (DR & ~MotorIn) | (DRIn & MotorIn);
                        busy_nx  = 1'b1;
`ifdef DIR_SETUP_EN
                        state_nx = SETUP;
                        phase_nx = SU_LOAD;
`else
                        state_nx = HIGH;
                        phase_nx = HP_LOAD;
                        step_nx  = MotorIn;
`endif
                    end
                end
            end
`ifdef DIR_SETUP_EN
            SETUP: begin
                if (phase == '0) begin
                    state_nx = HIGH;
                    phase_nx = HP_LOAD;
                    step_nx  = sel;
                end else begin
                    phase_nx = phase - PW'(1);
                end
            end
`endif
            HIGH: begin
                if (phase == '0) begin
                    state_nx = LOW;
                    phase_nx = HP_LOAD;
                    step_nx  = '0;
                end else begin
                    phase_nx = phase - PW'(1);
                end
            end
            LOW: begin
                if (phase == '0) begin
                    count_nx = count - 10'd1;
                    if (count == 10'd1) begin
                        state_nx = IDLE;
                        busy_nx  = 1'b0;
                        done_nx  = 1'b1;
                    end else begin
                        state_nx = HIGH;
                        phase_nx = HP_LOAD;
                        step_nx  = sel;
                    end
                end else begin
                    phase_nx = phase - PW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pulse_gen.sv
// Scoreboard bench for pulse_gen: driver predicts each move outcome, monitor checks it on Done/Err.
// Honours DIR_SETUP_EN when the same macro is defined for the build.
module tb_pulse_gen;

    localparam int HP = 2;
    localparam int DS = 3;
`ifdef DIR_SETUP_EN
    localparam int SU_CYC = DS;
`else
    localparam int SU_CYC = 0;
`endif

    logic       sysclk = 1'b0;
    logic       INIT_n = 1'b0;
    logic       CmdValid = 1'b0;
    logic [5:0] MotorIn = '0;
    logic [9:0] PulseNum = '0;
    logic [5:0] DRIn = '0;
    logic       Busy;
    logic [5:0] Step;
    logic [5:0] DR;
    logic       Done;
    logic       Err;

    pulse_gen #(.HALF_PERIOD(HP), .DIR_SETUP(DS)) dut (
        .sysclk(sysclk), .INIT_n(INIT_n), .CmdValid(CmdValid), .MotorIn(MotorIn),
        .PulseNum(PulseNum), .DRIn(DRIn), .Busy(Busy), .Step(Step), .DR(DR),
        .Done(Done), .Err(Err)
    );

    always #5 sysclk = ~sysclk;

    typedef struct {
        bit         is_err;
        int         len;
        logic [5:0] dr;
        logic [5:0] sel;
        int         n;
    } exp_t;

    exp_t       sb[$];
    int         n_vec = 0;
    int         n_bad = 0;
    logic [5:0] dr_model = '0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: accumulates what the DUT did since the last event, compares on Done/Err.
    int         busy_cyc = 0;
    int         first_rise = -1;
    int         highs = 0;
    int         rises[6];
    logic [5:0] prev_step = '0;
    logic [5:0] prev_dr = '0;
    logic       prev_busy = 1'b0;
    bit         dr_ok = 1'b1;
    bit         step_ok = 1'b1;

    task automatic clear_mon();
        busy_cyc = 0;
        first_rise = -1;
        highs = 0;
        for (int b = 0; b < 6; b++) rises[b] = 0;
        dr_ok = 1'b1;
        step_ok = 1'b1;
    endtask

    always @(negedge sysclk) begin
        exp_t e;
        if (!INIT_n) begin
            clear_mon();
            prev_step = '0;
            prev_dr = '0;
            prev_busy = 1'b0;
        end else begin
            if (Busy) busy_cyc++;
            for (int b = 0; b < 6; b++) begin
                if (Step[b] && !prev_step[b]) begin
                    rises[b]++;
                    if (first_rise < 0) first_rise = busy_cyc;
                end
                if (Step[b]) highs++;
            end
            if (DR != prev_dr && !(Busy && !prev_busy)) dr_ok = 1'b0;
            if (Step != '0 && !Busy) step_ok = 1'b0;
            if (Done || Err) begin
                if (sb.size() == 0) begin
                    chk("unexpected_event", int'({Done, Err}), 0);
                end else begin
                    e = sb.pop_front();
                    chk("event_kind", int'({Done, Err}), e.is_err ? 1 : 2);
                    chk("busy_len", busy_cyc, e.len);
                    chk("dr", int'(DR), int'(e.dr));
                    for (int b = 0; b < 6; b++)
                        chk($sformatf("rises_%0d", b), rises[b], e.sel[b] ? e.n : 0);
                    chk("step_high_cycles", highs, HP * e.n);
                    chk("first_rise", first_rise, (e.n > 0) ? 1 + SU_CYC : -1);
                    chk("busy_at_event", int'(Busy), 0);
                    chk("dr_stable", int'(dr_ok), 1);
                    chk("step_only_while_busy", int'(step_ok), 1);
                end
                clear_mon();
            end
            prev_step = Step;
            prev_dr = DR;
            prev_busy = Busy;
        end
    end

    // Reference model: outcome decided from the command rules alone.
    task automatic send_now(input logic [5:0] m, input logic [9:0] n, input logic [5:0] d);
        exp_t e;
        MotorIn = m;
        PulseNum = n;
        DRIn = d;
        CmdValid = 1'b1;
        if (!Busy) begin
            if ($countones(m) != 1) begin
                e = '{1'b1, 0, dr_model, 6'b0, 0};
            end else if (n == 10'd0) begin
                e = '{1'b0, 0, dr_model, m, 0};
            end else begin
                dr_model = (dr_model & ~m) | (d & m);
                e = '{1'b0, 2 * HP * int'(n) + SU_CYC, dr_model, m, int'(n)};
            end
            sb.push_back(e);
        end
        @(negedge sysclk);
        CmdValid = 1'b0;
    endtask

    task automatic send(input logic [5:0] m, input logic [9:0] n, input logic [5:0] d);
        @(negedge sysclk);
        send_now(m, n, d);
    endtask

    task automatic wait_idle(input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            @(negedge sysclk);
            if (!Busy && sb.size() == 0) break;
        end
        n_vec++;
        if (i >= bound) begin
            n_bad++;
            $display("FAIL idle_timeout: still busy after %0d cycles, expected idle", bound);
        end
    endtask

    task automatic wait_done(input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            @(negedge sysclk);
            if (Done) break;
        end
        n_vec++;
        if (i >= bound) begin
            n_bad++;
            $display("FAIL done_timeout: no Done within %0d cycles", bound);
        end
    endtask

    initial begin
        logic [5:0] m;
        logic [9:0] n;
        #12;
        chk("rst_busy", int'(Busy), 0);
        chk("rst_step", int'(Step), 0);
        chk("rst_dr", int'(DR), 0);
        chk("rst_done", int'(Done), 0);
        chk("rst_err", int'(Err), 0);
        @(negedge sysclk);
        INIT_n = 1'b1;

        send(6'b000100, 10'd3, 6'b000100);
        wait_idle(200);

        send(6'b000011, 10'd5, 6'b111111);
        send(6'b000000, 10'd5, 6'b111111);
        wait_idle(50);

        send(6'b000001, 10'd0, 6'b000001);
        wait_idle(50);

        // Ignored command mid-move, then a back-to-back command on the Done cycle.
        send(6'b000010, 10'd2, 6'b000010);
        repeat (3) @(negedge sysclk);
        send_now(6'b001000, 10'd7, 6'b001000);
        wait_done(200);
        send_now(6'b100000, 10'd1, 6'b100000);
        wait_idle(200);

        // Asynchronous reset during a HIGH phase.
        send(6'b000001, 10'd5, 6'b000001);
        for (int i = 0; i < 50; i++) begin
            @(negedge sysclk);
            if (Step[0]) break;
        end
        #3 INIT_n = 1'b0;
        #1;
        chk("async_rst_step", int'(Step), 0);
        chk("async_rst_busy", int'(Busy), 0);
        chk("async_rst_dr", int'(DR), 0);
        sb.delete();
        dr_model = '0;
        repeat (2) @(negedge sysclk);
        INIT_n = 1'b1;
        send(6'b000001, 10'd2, 6'b000000);
        wait_idle(200);

        send(6'b010000, 10'd1023, 6'b010000);
        wait_idle(5000);

        repeat (40) begin
            if ($urandom_range(0, 3) == 0) m = 6'($urandom);
            else m = 6'b1 << $urandom_range(0, 5);
            n = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom_range(1, 6));
            send(m, n, 6'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 5)) @(negedge sysclk);
                send_now(6'b1 << $urandom_range(0, 5), 10'($urandom_range(1, 6)), 6'($urandom));
            end
            wait_idle(500);
        end

        repeat (3) @(negedge sysclk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
